// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: recovers hex digits and decimal points
// from a multiplexed 7-segment scan by dwell-qualified sampling.
//
// Ports:
//   mclk           system clock, rising edge
//   rst_n          synchronous active-low reset
//   an[7:0]        anode enables, active-low, an[0] = digit 1
//   seg[6:0]       cathodes {g,f,e,d,c,b,a}, active-low
//   dp             decimal point cathode, active-low
//   out1..out8     recovered hex value per digit
//   dp_cap[7:0]    recovered decimal points, 1 = lit
//   dig_valid[7:0] digit holds a successfully decoded value
//   frame_done     pulse when all 8 digits seen since last pulse
//   err            pulse on illegal anode or segment pattern
module seg_scan_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       mclk,
  input  logic       rst_n,
  input  logic [7:0] an,
  input  logic [6:0] seg,
  input  logic       dp,
  output logic [3:0] out1,
  output logic [3:0] out2,
  output logic [3:0] out3,
  output logic [3:0] out4,
  output logic [3:0] out5,
  output logic [3:0] out6,
  output logic [3:0] out7,
  output logic [3:0] out8,
  output logic [7:0] dp_cap,
  output logic [7:0] dig_valid,
  output logic       frame_done,
  output logic       err
);

  localparam logic [7:0] STAB = 8'(STABLE_CYCLES);

  // sample stage (s_*) and the sample before it (p_*)
  logic [7:0] s_an;
  logic [6:0] s_seg;
  logic       s_dp;
  logic [7:0] p_an;
  logic [6:0] p_seg;
  logic       p_dp;

  logic [7:0] cnt;
  logic [7:0] cnt_nxt;
  logic       changed;
  logic       capture;

  logic [7:0] anl;
  logic       blank;
  logic       single;
  logic       multi;
  logic [2:0] idx;
  logic       legal;
  logic [3:0] hex;

  logic [3:0] dig_q [8];
  logic [7:0] seen;
  logic [7:0] seen_set;

  function automatic logic [4:0] seg_dec(
    input logic [6:0] p
  );
    logic [4:0] r;
    case (p)
      7'h3F:   r = {1'b1, 4'h0};
      7'h06:   r = {1'b1, 4'h1};
      7'h5B:   r = {1'b1, 4'h2};
      7'h4F:   r = {1'b1, 4'h3};
      7'h66:   r = {1'b1, 4'h4};
      7'h6D:   r = {1'b1, 4'h5};
      7'h7D:   r = {1'b1, 4'h6};
      7'h07:   r = {1'b1, 4'h7};
      7'h7F:   r = {1'b1, 4'h8};
      7'h6F:   r = {1'b1, 4'h9};
      7'h77:   r = {1'b1, 4'hA};
      7'h7C:   r = {1'b1, 4'hB};
      7'h39:   r = {1'b1, 4'hC};
      7'h5E:   r = {1'b1, 4'hD};
      7'h79:   r = {1'b1, 4'hE};
      7'h71:   r = {1'b1, 4'hF};
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  always_ff @(posedge mclk) begin
    if (!rst_n) begin
      s_an  <= 8'hFF;
      s_seg <= 7'h7F;
      s_dp  <= 1'b1;
      p_an  <= 8'hFF;
      p_seg <= 7'h7F;
      p_dp  <= 1'b1;
      cnt   <= 8'd0;
    end else begin
      s_an  <= an;
      s_seg <= seg;
      s_dp  <= dp;
      p_an  <= s_an;
      p_seg <= s_seg;
      p_dp  <= s_dp;
      cnt   <= cnt_nxt;
    end
  end

  // Capture fires on the edge the counter first reaches
  // STAB; a saturated counter (STAB = 255) must not refire,
  // hence the extra qualifier.
  always_comb begin
    changed = {s_an, s_seg, s_dp}
           != {p_an, p_seg, p_dp};
    if (changed) begin
      cnt_nxt = 8'd1;
    end else if (cnt == 8'hFF) begin
      cnt_nxt = cnt;
    end else begin
      cnt_nxt = cnt + 8'd1;
    end
    capture = (cnt_nxt == STAB)
           && (changed || cnt != STAB);
  end

  // anode class: one-hot test on the active-high view
  always_comb begin
    anl    = ~s_an;
    blank  = (anl == 8'd0);
    single = !blank
          && ((anl & (anl - 8'd1)) == 8'd0);
    multi  = !blank && !single;
    idx    = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (anl[i]) begin
        idx = 3'(i);
      end
    end
  end

  assign {legal, hex} = seg_dec(~s_seg);

  always_comb begin
    seen_set = seen;
    if (capture && single && legal) begin
      seen_set[idx] = 1'b1;
    end
  end

  always_ff @(posedge mclk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        dig_q[i] <= 4'h0;
      end
      dp_cap     <= 8'h00;
      dig_valid  <= 8'h00;
      seen       <= 8'h00;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      err        <= 1'b0;
      if (capture) begin
        unique case (1'b1)
          multi: begin
            err <= 1'b1;
          end
          single: begin
            dp_cap[idx] <= ~s_dp;
            if (legal) begin
              dig_q[idx]     <= hex;
              dig_valid[idx] <= 1'b1;
              // full mask closes the frame and restarts it
              if (seen_set == 8'hFF) begin
                seen       <= 8'h00;
                frame_done <= 1'b1;
              end else begin
                seen <= seen_set;
              end
            end else begin
              err            <= 1'b1;
              dig_valid[idx] <= 1'b0;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign out1 = dig_q[0];
  assign out2 = dig_q[1];
  assign out3 = dig_q[2];
  assign out4 = dig_q[3];
  assign out5 = dig_q[4];
  assign out6 = dig_q[5];
  assign out7 = dig_q[6];
  assign out8 = dig_q[7];

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: scoreboard bench for seg_scan_decoder
// with a dwell-level reference model and random scan traffic.
module tb_seg_scan_decoder;

  localparam int S = 4;

  logic       mclk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] an = 8'hFF;
  logic [6:0] seg = 7'h7F;
  logic       dp = 1'b1;
  logic [3:0] out1, out2, out3, out4;
  logic [3:0] out5, out6, out7, out8;
  logic [7:0] dp_cap;
  logic [7:0] dig_valid;
  logic       frame_done;
  logic       err;

  seg_scan_decoder #(.STABLE_CYCLES(S)) dut (
    .mclk(mclk),
    .rst_n(rst_n),
    .an(an),
    .seg(seg),
    .dp(dp),
    .out1(out1),
    .out2(out2),
    .out3(out3),
    .out4(out4),
    .out5(out5),
    .out6(out6),
    .out7(out7),
    .out8(out8),
    .dp_cap(dp_cap),
    .dig_valid(dig_valid),
    .frame_done(frame_done),
    .err(err)
  );

  always #5 mclk = ~mclk;

  typedef struct {
    int         at;
    logic [31:0] o;
    logic [7:0] dpc;
    logic [7:0] val;
    logic       e;
    logic       fd;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int fd_cnt = 0;

  int   ecnt = 0;
  logic rst_seen = 1'b0;
  always @(posedge mclk) begin
    ecnt     <= ecnt + 1;
    rst_seen <= rst_n;
  end

  logic [6:0] lut [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // reference state
  logic [31:0] m_o;
  logic [7:0]  m_dpc;
  logic [7:0]  m_val;
  logic [7:0]  m_seen;
  logic [7:0]  r_an;
  logic [6:0]  r_seg;
  logic        r_dp;
  int          r_start;
  int          r_len;

  function automatic logic [31:0] outs();
    return {out8, out7, out6, out5, out4, out3, out2, out1};
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  // Apply one dwell's effect at edge 'at' and queue it if visible.
  task automatic capture(input int at);
    int nz;
    int idx;
    int v;
    logic [31:0] o0;
    logic [7:0] d0;
    logic [7:0] v0;
    logic e;
    logic fd;
    exp_t x;
    e  = 1'b0;
    fd = 1'b0;
    o0 = m_o;
    d0 = m_dpc;
    v0 = m_val;
    nz = $countones(~r_an);
    if (nz == 0) return;
    if (nz > 1) begin
      e = 1'b1;
    end else begin
      idx = 0;
      for (int i = 0; i < 8; i++)
        if (!r_an[i]) idx = i;
      v = -1;
      for (int j = 0; j < 16; j++)
        if (lut[j] == ~r_seg) v = j;
      m_dpc[idx] = ~r_dp;
      if (v < 0) begin
        e = 1'b1;
        m_val[idx] = 1'b0;
      end else begin
        m_o[4*idx +: 4] = v[3:0];
        m_val[idx] = 1'b1;
        m_seen[idx] = 1'b1;
        if (m_seen == 8'hFF) begin
          fd = 1'b1;
          m_seen = 8'h00;
        end
      end
    end
    if (e || fd || m_o != o0 || m_dpc != d0 || m_val != v0) begin
      x.at  = at;
      x.o   = m_o;
      x.dpc = m_dpc;
      x.val = m_val;
      x.e   = e;
      x.fd  = fd;
      sb.push_back(x);
    end
  endtask

  // Called just after an edge; holds the pattern for n edges.
  task automatic hold(input logic [7:0] a,
                      input logic [6:0] s,
                      input logic d,
                      input int n);
    int prev;
    an  = a;
    seg = s;
    dp  = d;
    if ({a, s, d} == {r_an, r_seg, r_dp}) begin
      prev = r_len;
      r_len += n;
    end else begin
      r_an    = a;
      r_seg   = s;
      r_dp    = d;
      r_start = ecnt;
      prev    = 0;
      r_len   = n;
    end
    if (prev < S && r_len >= S)
      capture(r_start + 1 + S);
    repeat (n) @(posedge mclk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) @(posedge mclk);
    #1;
    rst_n   = 1'b1;
    m_o     = 32'h0;
    m_dpc   = 8'h00;
    m_val   = 8'h00;
    m_seen  = 8'h00;
    r_an    = an;
    r_seg   = seg;
    r_dp    = dp;
    r_start = ecnt;
    r_len   = 0;
  endtask

  task automatic blank(input int n);
    hold(8'hFF, 7'h7F, 1'b1, n);
  endtask

  task automatic scan(input logic [31:0] vals,
                      input logic [7:0] dpl,
                      input int cnt_d,
                      input int n);
    for (int i = 0; i < cnt_d; i++)
      hold(~(8'h01 << i), ~lut[vals[4*i +: 4]], ~dpl[i], n);
  endtask

  // monitor: pops the scoreboard whenever the DUT shows activity
  initial begin : monitor
    logic [31:0] o;
    logic [31:0] p_o;
    logic [7:0]  p_dpc;
    logic [7:0]  p_val;
    exp_t x;
    p_o   = 32'h0;
    p_dpc = 8'h00;
    p_val = 8'h00;
    forever begin
      @(negedge mclk);
      o = outs();
      if (!rst_seen) begin
        total++;
        if (o !== 32'h0 || dp_cap !== 8'h00
            || dig_valid !== 8'h00 || err !== 1'b0
            || frame_done !== 1'b0) begin
          bad++;
          $display("FAIL reset@%0d: outs=%h dpc=%h val=%h e=%b fd=%b want all 0",
                   ecnt, o, dp_cap, dig_valid, err, frame_done);
        end
        p_o   = 32'h0;
        p_dpc = 8'h00;
        p_val = 8'h00;
      end else begin
        while (sb.size() > 0 && sb[0].at < ecnt) begin
          total++;
          bad++;
          $display("FAIL missing@%0d: event due at edge %0d not seen",
                   ecnt, sb[0].at);
          void'(sb.pop_front());
        end
        if (frame_done === 1'b1) fd_cnt++;
        if (err !== 1'b0 || frame_done !== 1'b0 || o !== p_o
            || dp_cap !== p_dpc || dig_valid !== p_val) begin
          total++;
          if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected@%0d: outs=%h dpc=%h val=%h e=%b fd=%b want no activity",
                     ecnt, o, dp_cap, dig_valid, err, frame_done);
          end else begin
            x = sb.pop_front();
            if (x.at != ecnt || x.o !== o || x.dpc !== dp_cap
                || x.val !== dig_valid || x.e !== err
                || x.fd !== frame_done) begin
              bad++;
              $display("FAIL event@%0d: outs=%h dpc=%h val=%h e=%b fd=%b want @%0d outs=%h dpc=%h val=%h e=%b fd=%b",
                       ecnt, o, dp_cap, dig_valid, err, frame_done,
                       x.at, x.o, x.dpc, x.val, x.e, x.fd);
            end
          end
        end
        p_o   = o;
        p_dpc = dp_cap;
        p_val = dig_valid;
      end
    end
  end

  initial begin : stim
    int c;
    int i;
    int j;
    int n;
    int fd0;
    logic [7:0] a;
    logic [6:0] s;

    do_reset(3);
    blank(5);

    // single digit 1 = A, dp dark
    hold(8'hFE, ~7'h77, 1'b1, 6);
    chk("d1_out1", {28'h0, out1}, 32'hA);
    chk("d1_valid", {24'h0, dig_valid}, 32'h01);
    chk("d1_dpc", {24'h0, dp_cap}, 32'h00);
    blank(5);

    // two anodes low
    hold(8'hFC, 7'h40, 1'b1, 10);
    blank(4);
    chk("multi_valid", {24'h0, dig_valid}, 32'h01);

    // digit 3 all segments dark: not in table
    hold(8'hFB, 7'h7F, 1'b1, 10);
    blank(4);
    chk("illegal_valid", {24'h0, dig_valid}, 32'h01);
    chk("illegal_out3", {28'h0, out3}, 32'h0);

    // glitch: one dwell cycle short
    hold(8'hFD, ~lut[2], 1'b1, S - 1);
    blank(6);
    chk("glitch_valid", {24'h0, dig_valid}, 32'h01);

    // partial scan, reset mid-dwell, then full scan
    fd0 = fd_cnt;
    scan(32'h0000_0321, 8'h00, 6, 6);
    hold(8'hBF, ~lut[7], 1'b1, 2);
    do_reset(2);
    chk("reset_valid", {24'h0, dig_valid}, 32'h00);
    scan(32'h4321_DCBA, 8'h10, 8, 1000);
    chk("scan_outs", outs(), 32'h4321_DCBA);
    chk("scan_dpc", {24'h0, dp_cap}, 32'h10);
    chk("scan_valid", {24'h0, dig_valid}, 32'hFF);
    chk("scan_fd", fd_cnt - fd0, 1);

    // reset aborts a dwell; a full dwell after release captures
    hold(8'h7F, ~lut[5], 1'b1, 2);
    do_reset(2);
    hold(8'h7F, ~lut[5], 1'b1, S);
    blank(3);
    chk("rel_out8", {28'h0, out8}, 32'h5);
    chk("rel_valid", {24'h0, dig_valid}, 32'h80);

    // random dwells
    for (int t = 0; t < 400; t++) begin
      c = $urandom_range(0, 9);
      i = $urandom_range(0, 7);
      if (c < 2) begin
        a = 8'hFF;
        s = 7'h7F;
      end else if (c < 8) begin
        a = ~(8'h01 << i);
        if (c == 7) s = 7'($urandom);
        else s = ~lut[$urandom_range(0, 15)];
      end else begin
        j = (i + 1 + $urandom_range(0, 6)) % 8;
        a = 8'($urandom) & ~(8'h01 << i) & ~(8'h01 << j);
        s = ~lut[$urandom_range(0, 15)];
      end
      if ($urandom_range(0, 4) == 0) n = $urandom_range(1, S - 1);
      else n = $urandom_range(S, S + 6);
      hold(a, s, 1'($urandom), n);
    end

    blank(S + 4);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
